pipe_exec_ctrl: RTL and testbench

- Execution sequencer for the 5-stage MIPS pipeline.
- Accepts RUN, STEP and ABORT commands from the debug/host side over a valid/ready handshake.
- Drives the global pipeline enable, which gates all pipeline registers and the PC alongside the hazard unit's pc_write and IFID_write.
- Detects HALT in ID, drains the pipeline for a fixed number of cycles, reports completion, and counts executed cycles.

---
 rtl/pipe_exec_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_exec_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_exec_ctrl.sv
// rtl/pipe_exec_ctrl.sv - run/step/abort sequencer with HALT drain for the MIPS pipeline
// Optional breakpoint stop is built when PIPE_EXEC_CTRL_BREAKPOINT_EN is defined.
module pipe_exec_ctrl #(
    parameter int unsigned CYCLE_BITS   = 32,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned PC_BITS      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd,
    output logic                  o_cmd_ready,
    input  logic                  i_halt_id,
    output logic                  o_pipe_en,
    output logic                  o_pc_clear,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_state,
    output logic [CYCLE_BITS-1:0] o_cycle_count
`ifdef PIPE_EXEC_CTRL_BREAKPOINT_EN
    ,
    input  logic [PC_BITS-1:0]    i_pc,
    input  logic                  i_bp_valid,
    input  logic [PC_BITS-1:0]    i_bp_addr,
    output logic                  o_bp_hit
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    // Out-of-range configurations fall back to a single drain cycle.
    localparam bit         CFG_LEGAL  = (DRAIN_CYCLES >= 1) && (DRAIN_CYCLES <= 15) && (PC_BITS >= 1);
    localparam logic [3:0] DRAIN_LOAD = CFG_LEGAL ? 4'(DRAIN_CYCLES) : 4'd1;

    state_t                state_q, state_d;
    logic [3:0]            drain_q, drain_d;
    logic                  done_q, done_d;
    logic                  pc_clear_q, pc_clear_d;
    logic [CYCLE_BITS-1:0] cnt_q, cnt_d;
    logic                  bp_hit_q, bp_hit_d;

    logic pipe_en;
    logic cmd_ready;
    logic cmd_accept;
    logic cmd_abort;
    logic bp_match;

    assign pipe_en    = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
    assign cmd_accept = i_cmd_valid && cmd_ready;
    assign cmd_abort  = cmd_accept && (i_cmd == CMD_ABORT);

`ifdef PIPE_EXEC_CTRL_BREAKPOINT_EN
    assign bp_match = i_bp_valid && (i_pc == i_bp_addr);
    assign o_bp_hit = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        pc_clear_d = 1'b0;
        bp_hit_d   = 1'b0;
        cnt_d      = cnt_q;

        if (pipe_en && (cnt_q != {CYCLE_BITS{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        // ABORT wins over both the counter increment and HALT in the same cycle.
        if (cmd_abort) begin
            state_d    = ST_IDLE;
            pc_clear_d = 1'b1;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_accept && (i_cmd == CMD_RUN)) begin
                        state_d = ST_RUN;
                    end else if (cmd_accept && (i_cmd == CMD_STEP)) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (i_halt_id) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else if (bp_match) begin
                        state_d  = ST_IDLE;
                        bp_hit_d = 1'b1;
                    end
                end
                ST_STEP: begin
                    if (i_halt_id) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    drain_d = drain_q - 4'd1;
                    if (drain_q <= 4'd1) begin
                        state_d = ST_DONE;
                        drain_d = 4'd0;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    drain_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            drain_q    <= 4'd0;
            done_q     <= 1'b0;
            pc_clear_q <= 1'b0;
            bp_hit_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            pc_clear_q <= pc_clear_d;
            bp_hit_q   <= bp_hit_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_cmd_ready   = cmd_ready;
    assign o_pipe_en     = pipe_en;
    assign o_busy        = pipe_en;
    assign o_done        = done_q;
    assign o_pc_clear    = pc_clear_q;
    assign o_state       = state_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// tb/tb_pipe_exec_ctrl.sv - directed scoreboard bench for pipe_exec_ctrl (default build)
module tb_pipe_exec_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        halt_id;
    logic        pipe_en;
    logic        pc_clear;
    logic        busy;
    logic        done;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic        pe;
        logic        dn;
        logic        pcc;
        logic        rdy;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    pipe_exec_ctrl #(
        .CYCLE_BITS  (32),
        .DRAIN_CYCLES(4),
        .PC_BITS     (32)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .o_cmd_ready  (cmd_ready),
        .i_halt_id    (halt_id),
        .o_pipe_en    (pipe_en),
        .o_pc_clear   (pc_clear),
        .o_busy       (busy),
        .o_done       (done),
        .o_state      (state),
        .o_cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic pe, input logic dn,
                            input logic pcc, input logic rdy, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.st = st; e.pe = pe; e.dn = dn; e.pcc = pcc; e.rdy = rdy; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare the DUT against the oldest scoreboard entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".state"}, 32'(state), 32'(e.st));
        chk({e.tag, ".pipe_en"}, 32'(pipe_en), 32'(e.pe));
        chk({e.tag, ".busy"}, 32'(busy), 32'(e.pe));
        chk({e.tag, ".done"}, 32'(done), 32'(e.dn));
        chk({e.tag, ".pc_clear"}, 32'(pc_clear), 32'(e.pcc));
        chk({e.tag, ".cmd_ready"}, 32'(cmd_ready), 32'(e.rdy));
        chk({e.tag, ".count"}, cycle_count, e.cnt);
    endtask

    task automatic step(input string tag, input logic [2:0] st, input logic pe, input logic dn,
                        input logic pcc, input logic rdy, input logic [31:0] cnt);
        push_exp(tag, st, pe, dn, pcc, rdy, cnt);
        tick();
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic h);
        cmd_valid = v;
        cmd       = c;
        halt_id   = h;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0);
        step("rst0", 3'd0, 0, 0, 0, 1, 0);
        step("rst1", 3'd0, 0, 0, 0, 1, 0);
        reset = 1'b0;

        // RUN with HALT on the 10th enabled cycle: 10 + 4 enabled cycles.
        drive(1'b1, 2'b01, 1'b0);
        step("run_acc", 3'd1, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) drive(1'b1, 2'b10, 1'b0);
            else drive(1'b0, 2'b00, 1'b0);
            step("run_cyc", 3'd1, 1, 0, 0, 1, 32'(k));
        end
        drive(1'b0, 2'b00, 1'b1);
        step("halt", 3'd3, 1, 0, 0, 0, 10);
        drive(1'b0, 2'b00, 1'b0);
        step("drain1", 3'd3, 1, 0, 0, 0, 11);
        step("drain2", 3'd3, 1, 0, 0, 0, 12);
        step("drain3", 3'd3, 1, 0, 0, 0, 13);
        step("done", 3'd4, 0, 1, 0, 1, 14);
        drive(1'b1, 2'b10, 1'b0);
        step("done_step_ign", 3'd4, 0, 0, 0, 1, 14);

        // ABORT from DONE clears count and pulses pc_clear once.
        drive(1'b1, 2'b11, 1'b0);
        step("abort_done", 3'd0, 0, 0, 1, 1, 0);
        drive(1'b0, 2'b00, 1'b0);
        step("abort_done_after", 3'd0, 0, 0, 0, 1, 0);

        // Three single STEPs separated by idle gaps.
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 2'b10, 1'b0);
            step("step_in", 3'd2, 1, 0, 0, 0, 32'(s));
            drive(1'b0, 2'b00, 1'b0);
            step("step_out", 3'd0, 0, 0, 0, 1, 32'(s + 1));
            step("step_gap", 3'd0, 0, 0, 0, 1, 32'(s + 1));
        end

        // ABORT and HALT together in RUN: ABORT wins, no DRAIN.
        drive(1'b1, 2'b01, 1'b0);
        step("run2_acc", 3'd1, 1, 0, 0, 1, 3);
        drive(1'b0, 2'b00, 1'b0);
        step("run2_cyc", 3'd1, 1, 0, 0, 1, 4);
        drive(1'b1, 2'b11, 1'b1);
        step("abort_halt", 3'd0, 0, 0, 1, 1, 0);
        drive(1'b0, 2'b00, 1'b0);
        step("abort_halt_after", 3'd0, 0, 0, 0, 1, 0);

        // ABORT held through DRAIN is only accepted in DONE.
        drive(1'b1, 2'b01, 1'b0);
        step("run3_acc", 3'd1, 1, 0, 0, 1, 0);
        drive(1'b0, 2'b00, 1'b1);
        step("run3_halt", 3'd3, 1, 0, 0, 0, 1);
        drive(1'b1, 2'b11, 1'b0);
        step("held_d1", 3'd3, 1, 0, 0, 0, 2);
        step("held_d2", 3'd3, 1, 0, 0, 0, 3);
        step("held_d3", 3'd3, 1, 0, 0, 0, 4);
        step("held_done", 3'd4, 0, 1, 0, 1, 5);
        step("held_acc", 3'd0, 0, 0, 1, 1, 0);
        drive(1'b0, 2'b00, 1'b0);
        step("held_after", 3'd0, 0, 0, 0, 1, 0);

        // Reset in the middle of DRAIN.
        drive(1'b1, 2'b01, 1'b0);
        step("run4_acc", 3'd1, 1, 0, 0, 1, 0);
        drive(1'b0, 2'b00, 1'b1);
        step("run4_halt", 3'd3, 1, 0, 0, 0, 1);
        drive(1'b0, 2'b00, 1'b0);
        step("run4_d1", 3'd3, 1, 0, 0, 0, 2);
        reset = 1'b1;
        step("mid_rst", 3'd0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        step("post_rst1", 3'd0, 0, 0, 0, 1, 0);
        step("post_rst2", 3'd0, 0, 0, 0, 1, 0);
        step("post_rst3", 3'd0, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
